i2c_target_regfile: RTL and testbench
=====================================

// Module: i2c_target_regfile
// PURPOSE
// I2C target (slave) responder: the far end of the SoC's Wishbone I2C controller.
// Decodes START/STOP, matches a 7-bit address, ACKs and serves a NUM_REGS x 8 register bank
// with an auto-incrementing pointer. A local port gives SoC/bench logic access to the same bank.
// Used as a loopback target for controller bring-up and as an on-chip I2C-visible mailbox.
// PARAMETERS
// TARGET_ADDR  7'h50  7-bit I2C address this block responds to
// NUM_REGS     16     register bank depth; power of 2, 2..256
// FILT_LEN     3      consecutive equal samples required to accept a new SCL/SDA level (>=1)
// PORTS
// clk        in   1            system clock; must be >= 20x SCL frequency
// rst        in   1            synchronous, active-high reset
// scl_i      in   1            SCL pad input (asynchronous)
// sda_i      in   1            SDA pad input (asynchronous)
// sda_oe     out  1            1 = pull SDA low (open-drain); 0 = release. Never drives high
// loc_we     in   1            local write strobe, 1 cycle
// loc_addr   in   log2(NUM_REGS)  local read/write index
// loc_wdata  in   8            local write data
// loc_rdata  out  8            bank[loc_addr], registered, 1-cycle read latency
// wr_done    out  1            1-cycle pulse on STOP after a transfer that wrote >=1 data byte
// busy       out  1            1 from accepted START to STOP
// BEHAVIOUR
// - Reset: sda_oe=0, loc_rdata=0, wr_done=0, busy=0, ptr=0, all bank entries 0, FSM=IDLE.
//   Reset mid-transfer releases SDA in the same cycle as the reset edge; bus traffic is ignored until next START.
// - Input path: 2-FF synchroniser, then glitch filter. Filtered level changes only after FILT_LEN
//   equal samples. Edges (scl_rise, scl_fall) are derived from the filtered levels.
// - START: filtered SDA falls while SCL high. STOP: filtered SDA rises while SCL high.
//   Either is honoured from any state, including a repeated START mid-byte.
// - START -> ADDR, bit_cnt=0. STOP -> IDLE, sda_oe=0.
// - Sampling: SDA is sampled on scl_rise, MSB first.
// - Driving: sda_oe is updated on the cycle after scl_fall. No clock stretching.
// - FSM states: IDLE, ADDR, ADDR_ACK, PTR, DATA_WR, WR_ACK, DATA_RD, RD_ACK, IGNORE.
// - ADDR: 8 bits shifted in (7 address bits + R/W).
//   Match -> ADDR_ACK: drive 0 for the ACK clock.
//   Mismatch -> IGNORE: no ACK; wait for START/STOP.
// - ADDR_ACK: on the following scl_fall, W=0 goes to PTR; R=1 goes to DATA_RD with shift_reg=bank[ptr].
// - PTR: first write byte; ptr <= byte mod NUM_REGS; ACK (WR_ACK); then DATA_WR.
// - DATA_WR: each byte is written to bank[ptr], then ptr++ (wraps NUM_REGS-1 -> 0).
//   Always ACKed, then DATA_WR again.
// - DATA_RD: MSB is driven first; sda_oe = ~shift_reg[7], so a 0 bit drives low and a 1 bit releases.
//   After 8 bits, release SDA and go to RD_ACK; ptr++ (wraps).
// - RD_ACK: sample master ACK on scl_rise.
//   ACK (0): reload shift_reg=bank[ptr], go to DATA_RD.
//   NACK (1): go to IGNORE (SDA released).
// - Bank commit: the I2C write commits on the ACK scl_rise.
//   Same-cycle collision with loc_we to the same index: the I2C write wins.
// - Local read: loc_rdata returns bank[loc_addr] one cycle after loc_addr is presented,
//   and reflects a same-cycle write only on the next cycle.
// - Read snapshot: a byte being transmitted is a snapshot taken at load time.
//   A later local write does not alter bits already in flight.
// - wr_done: set on STOP if >=1 DATA_WR byte completed since START; cleared by START.
//   A repeated START does not pulse wr_done.
// TESTING
// - Write 0x50/W, ptr 0x03, data 0xA5,0x5A, STOP -> ACK on all 4 bytes;
//   bank[3]=A5, bank[4]=5A; wr_done pulses once.
// - Local write bank[7]=0x3C, then I2C 0x50/W ptr 7, repeated START 0x50/R, read 1 byte, NACK ->
//   master sees 0x3C; SDA released after NACK.
// - Address 0x51/W -> no ACK (SDA released on 9th clock); bank unchanged; busy=1 until STOP.
// - NUM_REGS=16: ptr 0x0F, write 3 bytes 11,22,33 -> bank[15]=11, bank[0]=22, bank[1]=33 (wrap).
// - 1-cycle SDA glitch while SCL high (FILT_LEN=3) -> no START/STOP detected; transfer unaffected.
// - Assert rst mid-read with SDA held low -> sda_oe=0 in the cycle of the reset edge;
//   the next full transaction succeeds.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// I2C target serving a NUM_REGS x 8 register bank with an auto-incrementing pointer, plus a local port.
// SCL/SDA pass through a 2-FF synchroniser and a FILT_LEN glitch filter; all bus timing uses filtered edges.
module i2c_target_regfile #(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_oe,
  input  logic                        loc_we,
  input  logic [$clog2(NUM_REGS)-1:0] loc_addr,
  input  logic [7:0]                  loc_wdata,
  output logic [7:0]                  loc_rdata,
  output logic                        wr_done,
  output logic                        busy
);
  localparam int unsigned   AW      = $clog2(NUM_REGS);
  localparam int unsigned   CW      = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, DATA_WR, WR_ACK, DATA_RD, RD_ACK, IGNORE
  } state_t;

  logic [1:0]    scl_sync_q, sda_sync_q;
  logic [CW-1:0] scl_cnt_q, sda_cnt_q;
  logic          scl_flt_q, sda_flt_q, scl_prev_q, sda_prev_q;

  // Synchroniser and filter reset to the idle-bus level so reset itself never looks like a START.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_flt_q;
      sda_prev_q <= sda_flt_q;
      if (scl_sync_q[1] == scl_flt_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == CNT_MAX) begin
        scl_flt_q <= scl_sync_q[1];
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 1'b1;
      end
      if (sda_sync_q[1] == sda_flt_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == CNT_MAX) begin
        sda_flt_q <= sda_sync_q[1];
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 1'b1;
      end
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_flt_q & ~scl_prev_q;
  assign scl_fall  = ~scl_flt_q & scl_prev_q;
  assign start_det = scl_flt_q & scl_prev_q & sda_prev_q & ~sda_flt_q;
  assign stop_det  = scl_flt_q & scl_prev_q & ~sda_prev_q & sda_flt_q;

  state_t        state_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic [AW-1:0] ptr_q;
  logic          ptr_byte_q, wrote_q, sda_oe_q, busy_q, wr_done_q;
  logic [7:0]    loc_rdata_q;
  logic [7:0]    bank_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      ptr_byte_q  <= 1'b0;
      wrote_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_done_q   <= 1'b0;
      loc_rdata_q <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) bank_q[i] <= '0;
    end else begin
      wr_done_q   <= 1'b0;
      loc_rdata_q <= bank_q[loc_addr];
      // A same-cycle I2C commit below overrides this write when the indices collide.
      if (loc_we) bank_q[loc_addr] <= loc_wdata;

      if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b1;
        wrote_q   <= 1'b0;
      end else if (stop_det) begin
        state_q   <= IDLE;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
        wr_done_q <= wrote_q;
        wrote_q   <= 1'b0;
      end else begin
        case (state_q)
          ADDR, PTR, DATA_WR: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_flt_q};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              bit_cnt_q <= '0;
              if (state_q != ADDR) begin
                state_q    <= WR_ACK;
                sda_oe_q   <= 1'b1;
                ptr_byte_q <= (state_q == PTR);
              end else if (shift_q[7:1] == TARGET_ADDR) begin
                state_q  <= ADDR_ACK;
                sda_oe_q <= 1'b1;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (shift_q[0]) begin
                state_q  <= DATA_RD;
                shift_q  <= bank_q[ptr_q];
                sda_oe_q <= ~bank_q[ptr_q][7];
              end else begin
                state_q  <= PTR;
                sda_oe_q <= 1'b0;
              end
            end
          end
          WR_ACK: begin
            if (scl_rise) begin
              if (ptr_byte_q) begin
                ptr_q <= shift_q[AW-1:0];
              end else begin
                bank_q[ptr_q] <= shift_q;
                ptr_q         <= ptr_q + 1'b1;
                wrote_q       <= 1'b1;
              end
            end else if (scl_fall) begin
              state_q  <= DATA_WR;
              sda_oe_q <= 1'b0;
            end
          end
          DATA_RD: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                state_q   <= RD_ACK;
                sda_oe_q  <= 1'b0;
                ptr_q     <= ptr_q + 1'b1;
                bit_cnt_q <= '0;
              end else if (bit_cnt_q == 4'd0) begin
                sda_oe_q <= ~shift_q[7];
              end else begin
                shift_q  <= {shift_q[6:0], 1'b0};
                sda_oe_q <= ~shift_q[6];
              end
            end
          end
          RD_ACK: begin
            // Snapshot is taken at the ACK rise; MSB goes out on the following fall.
            if (scl_rise) begin
              if (sda_flt_q) begin
                state_q <= IGNORE;
              end else begin
                state_q   <= DATA_RD;
                shift_q   <= bank_q[ptr_q];
                bit_cnt_q <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_done   = wr_done_q;
  assign loc_rdata = loc_rdata_q;
endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master on a wired-AND SDA, plus a register-bank model.
module tb_i2c_target_regfile;
  localparam int NR = 16;
  localparam int Q  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       loc_we = 1'b0;
  logic [3:0] loc_addr = '0;
  logic [7:0] loc_wdata = '0;
  logic       sda_oe, wr_done, busy;
  logic [7:0] loc_rdata;
  logic       sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_regfile #(.TARGET_ADDR(7'h50), .NUM_REGS(NR), .FILT_LEN(3)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
    .wr_done(wr_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_done_cnt = 0;
  int exp_wr_done = 0;
  int mptr = 0;
  logic [7:0] mbank [NR];
  logic [7:0] txq [$];

  always @(negedge clk) if (wr_done) wr_done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_c();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic [7:0] gl, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; tick(Q);
      scl_m = 1'b1; tick(Q / 2);
      if (gl[i]) sda_m = ~b[i];
      tick(1);
      sda_m = b[i]; tick(Q + Q / 2 - 1);
      scl_m = 1'b0; tick(Q);
    end
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    ack = sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      d[i] = sda_bus; tick(Q);
      scl_m = 1'b0; tick(Q);
    end
    sda_m = nack; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  // Write transaction: address a, pointer p, data bytes from txq.
  task automatic do_write(input logic [6:0] a, input logic [7:0] p, input logic [7:0] gl);
    logic ack;
    logic hit;
    hit = (a == 7'h50);
    start_c();
    chk("busy_start", busy, 1);
    wr_byte({a, 1'b0}, 8'h00, ack);
    chk("addr_ack", ack, hit ? 0 : 1);
    wr_byte(p, 8'h00, ack);
    chk("ptr_ack", ack, hit ? 0 : 1);
    if (hit) mptr = p % NR;
    foreach (txq[i]) begin
      wr_byte(txq[i], gl, ack);
      chk("data_ack", ack, hit ? 0 : 1);
      if (hit) begin
        mbank[mptr] = txq[i];
        mptr = (mptr + 1) % NR;
      end
    end
    chk("busy_xfer", busy, 1);
    stop_c();
    if (hit && txq.size() > 0) exp_wr_done++;
    chk("busy_stop", busy, 0);
    chk("wr_done_cnt", wr_done_cnt, exp_wr_done);
  endtask

  // Set pointer, repeated START, read n bytes (ACK all but last), STOP.
  task automatic do_read(input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] d;
    start_c();
    wr_byte({7'h50, 1'b0}, 8'h00, ack);
    chk("rd_addrw_ack", ack, 0);
    wr_byte(p, 8'h00, ack);
    chk("rd_ptr_ack", ack, 0);
    mptr = p % NR;
    start_c();
    wr_byte({7'h50, 1'b1}, 8'h00, ack);
    chk("rd_addrr_ack", ack, 0);
    for (int k = 0; k < n; k++) begin
      rd_byte(k == n - 1, d);
      chk("rd_data", d, mbank[mptr]);
      mptr = (mptr + 1) % NR;
    end
    chk("rd_release", sda_oe, 0);
    chk("rd_busy", busy, 1);
    stop_c();
    chk("rd_wr_done_cnt", wr_done_cnt, exp_wr_done);
  endtask

  task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
    loc_we = 1'b1; loc_addr = a; loc_wdata = d;
    tick(1);
    loc_we = 1'b0;
    mbank[a] = d;
  endtask

  task automatic check_bank();
    for (int i = 0; i < NR; i++) begin
      loc_addr = 4'(i);
      tick(1);
      chk($sformatf("bank[%0d]", i), loc_rdata, mbank[i]);
    end
  endtask

  typedef struct {
    logic       we;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } lvec_t;

  lvec_t lv [9];

  initial begin
    logic ack;
    logic [7:0] d;
    int op, n;
    logic [6:0] ra;
    logic [7:0] rp;

    lv[0] = '{1'b1, 4'd2,  8'h11, 8'h00};
    lv[1] = '{1'b0, 4'd2,  8'h00, 8'h11};
    lv[2] = '{1'b1, 4'd2,  8'h22, 8'h11};
    lv[3] = '{1'b0, 4'd2,  8'h00, 8'h22};
    lv[4] = '{1'b1, 4'd15, 8'hFF, 8'h00};
    lv[5] = '{1'b0, 4'd15, 8'h00, 8'hFF};
    lv[6] = '{1'b0, 4'd0,  8'h00, 8'h00};
    lv[7] = '{1'b1, 4'd0,  8'h80, 8'h00};
    lv[8] = '{1'b0, 4'd0,  8'h00, 8'h80};
    for (int i = 0; i < NR; i++) mbank[i] = 8'h00;

    tick(5);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_loc_rdata", loc_rdata, 0);
    rst = 1'b0;
    tick(2);
    check_bank();

    // Local port vectors.
    for (int i = 0; i < 9; i++) begin
      loc_we = lv[i].we; loc_addr = lv[i].a; loc_wdata = lv[i].d;
      tick(1);
      chk($sformatf("loc_vec%0d", i), loc_rdata, lv[i].exp);
      if (lv[i].we) mbank[lv[i].a] = lv[i].d;
    end
    loc_we = 1'b0;
    tick(Q);

    // Basic write of two bytes at pointer 3.
    txq = '{8'hA5, 8'h5A};
    do_write(7'h50, 8'h03, 8'h00);
    chk("w1_bank3", mbank[3], 8'hA5);
    check_bank();

    // Local write then I2C read back with NACK.
    loc_write(4'd7, 8'h3C);
    do_read(8'h07, 1);

    // Wrong address: no ACK anywhere, bank untouched.
    txq = '{8'hEE};
    do_write(7'h51, 8'h03, 8'h00);
    check_bank();

    // Pointer wrap past the last register.
    txq = '{8'h11, 8'h22, 8'h33};
    do_write(7'h50, 8'h0F, 8'h00);
    chk("wrap_bank0", mbank[0], 8'h22);
    check_bank();

    // Single-cycle SDA glitches in every bit while SCL is high.
    txq = '{8'hA5, 8'h3C};
    do_write(7'h50, 8'h08, 8'hFF);
    check_bank();
    do_read(8'h08, 2);

    // Reset while the target is pulling SDA low during a read.
    loc_write(4'd9, 8'h12);
    start_c();
    wr_byte({7'h50, 1'b0}, 8'h00, ack);
    wr_byte(8'h09, 8'h00, ack);
    start_c();
    wr_byte({7'h50, 1'b1}, 8'h00, ack);
    chk("pre_rst_ack", ack, 0);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    chk("pre_rst_drive", sda_oe, 1);
    rst = 1'b1;
    tick(1);
    chk("rst_release", sda_oe, 0);
    scl_m = 1'b1; sda_m = 1'b1;
    tick(10);
    chk("rst_busy2", busy, 0);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) mbank[i] = 8'h00;
    mptr = 0;
    tick(Q);
    txq = '{8'h77, 8'h99};
    do_write(7'h50, 8'h02, 8'h00);
    do_read(8'h02, 2);
    check_bank();

    // Randomized traffic against the bank model.
    for (int r = 0; r < 12; r++) begin
      op = $urandom_range(0, 2);
      rp = 8'($urandom_range(0, 255));
      n  = $urandom_range(1, 3);
      if (op == 0) begin
        ra = ($urandom_range(0, 4) == 0) ? (7'h50 ^ (7'd1 << $urandom_range(0, 6))) : 7'h50;
        txq = {};
        for (int k = 0; k < n; k++) txq.push_back(8'($urandom));
        do_write(ra, rp, 8'h00);
      end else if (op == 1) begin
        do_read(rp, n);
      end else begin
        for (int k = 0; k < n; k++) loc_write(4'($urandom_range(0, NR - 1)), 8'($urandom));
        tick(2);
      end
    end
    check_bank();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
